// File: rtl/switch_demultiplexer.sv
// Latched 1->4 demux: debounced switch 1 is routed to the LED picked by a select that steps on switch-2 release;
// switch-3 press clears all LEDs. Latency: input change -> LED is 2 sync + DEBOUNCE_LIMIT + 1 cycles, no backpressure.
module switch_demultiplexer #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic [2:0]         sw_raw;
    logic [2:0]         sync1_q;
    logic [2:0]         sync2_q;
    logic [2:0]         deb_q;
    logic [2:0]         deb_d;
    logic [2:1]         deb_prev_q;
    logic [2:0][CW-1:0] cnt_q;
    logic [2:0][CW-1:0] cnt_d;
    logic [1:0]         sel_q;
    logic [1:0]         sel_d;
    logic [3:0]         hold_q;
    logic [3:0]         hold_d;
    logic               adv;
    logic               clr;

    assign sw_raw = {i_Switch_3, i_Switch_2, i_Switch_1};

    // A switch must disagree with its debounced state for DEBOUNCE_LIMIT
    // consecutive cycles before the state flips; any agreement restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign adv = deb_prev_q[1] & ~deb_q[1];
    assign clr = ~deb_prev_q[2] & deb_q[2];

    // Data is written through the pre-advance select; clear wins over the write.
    always_comb begin
        sel_d  = adv ? sel_q + 2'd1 : sel_q;
        hold_d = hold_q;
        if (clr) begin
            hold_d = 4'b0000;
        end else begin
            hold_d[sel_q] = deb_q[0];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            hold_q     <= '0;
        end else begin
            sync1_q    <= sw_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q[2:1];
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
        end
    end

    assign o_LED_1 = hold_q[0];
    assign o_LED_2 = hold_q[1];
    assign o_LED_3 = hold_q[2];
    assign o_LED_4 = hold_q[3];

endmodule

// File: tb/tb_switch_demultiplexer.sv
// Bench for switch_demultiplexer with DEBOUNCE_LIMIT=4: directed vector table plus random switch
// activity, every cycle compared against an event-level reference model.
module tb_switch_demultiplexer;

    localparam int LIM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sw1;
    logic sw2;
    logic sw3;
    logic led1;
    logic led2;
    logic led3;
    logic led4;

    switch_demultiplexer #(.DEBOUNCE_LIMIT(LIM)) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Switch_1(sw1),
        .i_Switch_2(sw2),
        .i_Switch_3(sw3),
        .o_LED_1   (led1),
        .o_LED_2   (led2),
        .o_LED_3   (led3),
        .o_LED_4   (led4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw samples reach the debouncer two edges late; a debounced
    // state flips once the last LIM synced samples all disagree with it; a flip
    // schedules its select/clear event for the following edge.
    logic [2:0] m_pipe[$];
    logic [2:0] m_win[$];
    logic [2:0] m_deb;
    int         m_sel;
    logic [3:0] m_hold;
    bit         m_adv_p;
    bit         m_clr_p;

    task automatic model_edge();
        logic [2:0] synced;
        bit         all_diff;
        if (!rst_n) begin
            m_pipe.delete();
            m_pipe.push_back(3'b000);
            m_pipe.push_back(3'b000);
            m_win.delete();
            m_deb   = 3'b000;
            m_sel   = 0;
            m_hold  = 4'b0000;
            m_adv_p = 1'b0;
            m_clr_p = 1'b0;
        end else begin
            if (m_clr_p) m_hold = 4'b0000;
            else         m_hold[m_sel] = m_deb[0];
            if (m_adv_p) m_sel = (m_sel + 1) % 4;
            m_adv_p = 1'b0;
            m_clr_p = 1'b0;
            m_pipe.push_back({sw3, sw2, sw1});
            synced = m_pipe.pop_front();
            m_win.push_back(synced);
            if (m_win.size() > LIM) void'(m_win.pop_front());
            if (m_win.size() == LIM) begin
                for (int i = 0; i < 3; i++) begin
                    all_diff = 1'b1;
                    foreach (m_win[k]) if (m_win[k][i] == m_deb[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_deb[i] = ~m_deb[i];
                        if (i == 1 && !m_deb[1]) m_adv_p = 1'b1;
                        if (i == 2 &&  m_deb[2]) m_clr_p = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string nm, input logic [3:0] exp, input logic [3:0] act);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: LEDs got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", m_hold, {led4, led3, led2, led1});
    endtask

    task automatic drive(input bit r, input bit a, input bit b, input bit c, input int n);
        rst_n = r;
        sw1   = a;
        sw2   = b;
        sw3   = c;
        repeat (n) step();
    endtask

    typedef struct {
        bit         r;
        bit         s1;
        bit         s2;
        bit         s3;
        int         n;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit a, input bit b, input bit c, input int n,
                       input logic [3:0] exp);
        vec_t v;
        v.r = r; v.s1 = a; v.s2 = b; v.s3 = c; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        bit cr;
        bit c1;
        bit c2;
        bit c3;
        rst_n = 1'b0; sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1;

        // reset, then switch 1 held high reaches LED1 after 2+4+1 edges
        add(0, 1, 1, 1, 3, 4'b0000);
        add(1, 1, 0, 0, 6, 4'b0000);
        add(1, 1, 0, 0, 1, 4'b0001);
        // bouncing data never gets through; stable 0 does
        for (int k = 0; k < 5; k++) begin
            add(1, 0, 0, 0, 2, 4'b0001);
            add(1, 1, 0, 0, 2, 4'b0001);
        end
        add(1, 0, 0, 0, 6, 4'b0001);
        add(1, 0, 0, 0, 1, 4'b0000);
        // routing across all four destinations
        add(1, 1, 0, 0, 7, 4'b0001);
        add(1, 1, 1, 0, 8, 4'b0001); add(1, 1, 0, 0, 8, 4'b0011);
        add(1, 1, 1, 0, 8, 4'b0011); add(1, 1, 0, 0, 8, 4'b0111);
        add(1, 1, 1, 0, 8, 4'b0111); add(1, 1, 0, 0, 8, 4'b1111);
        add(1, 0, 0, 0, 7, 4'b0111);
        // wrap 3->0, then four more releases back to 0
        add(1, 0, 1, 0, 8, 4'b0111); add(1, 0, 0, 0, 8, 4'b0110);
        add(1, 1, 0, 0, 7, 4'b0111);
        add(1, 1, 1, 0, 8, 4'b0111); add(1, 1, 0, 0, 8, 4'b0111);
        add(1, 1, 1, 0, 8, 4'b0111); add(1, 1, 0, 0, 8, 4'b0111);
        add(1, 1, 1, 0, 8, 4'b0111); add(1, 1, 0, 0, 8, 4'b1111);
        add(1, 1, 1, 0, 8, 4'b1111); add(1, 1, 0, 0, 8, 4'b1111);
        add(1, 0, 0, 0, 7, 4'b1110);
        add(1, 1, 0, 0, 7, 4'b1111);
        // clear dominates a simultaneous data write; held press does not repeat
        add(1, 0, 0, 1, 6, 4'b1111);
        add(1, 0, 0, 1, 1, 4'b0000);
        add(1, 1, 0, 1, 7, 4'b0001);
        add(1, 1, 0, 0, 8, 4'b0001);
        // advance and clear on the same edge
        add(1, 1, 1, 0, 8, 4'b0001);
        add(1, 1, 0, 1, 6, 4'b0001);
        add(1, 1, 0, 1, 1, 4'b0000);
        add(1, 1, 0, 1, 1, 4'b0010);
        add(1, 1, 0, 0, 8, 4'b0010);
        // reset in the middle of a release count: no advance afterwards
        add(1, 1, 1, 0, 8, 4'b0010);
        add(1, 1, 0, 0, 4, 4'b0010);
        add(0, 1, 0, 0, 2, 4'b0000);
        add(1, 1, 0, 0, 8, 4'b0001);
        add(1, 1, 0, 0, 8, 4'b0001);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].n);
            check($sformatf("vec[%0d]", i), vecs[i].exp, {led4, led3, led2, led1});
        end

        // random switch activity with run lengths around the debounce limit
        c1 = 1'b1; c2 = 1'b0; c3 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cr = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 2) == 0) c1 = ~c1;
            if ($urandom_range(0, 2) == 0) c2 = ~c2;
            if ($urandom_range(0, 4) == 0) c3 = ~c3;
            drive(cr, c1, c2, c3, int'($urandom_range(1, 10)));
        end
        drive(1, 0, 0, 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
